wave_gen_mc: RTL

Multi-channel, parametrised direct-digital-synthesis waveform generator on the picosoc iomem bus. It supersedes the single-channel counter-based generator. Each of NCH channels has:
- a PHASE_W-bit phase accumulator, which sets frequency independently of period-counter resolution;
- a selectable wave shape with amplitude scaling;
- a 2-stage registered output pipeline.

A global sync register restarts all channels phase-aligned.

---
 rtl/wave_gen_pkg.sv | 21 ++
 rtl/wave_sine_lut.sv | 26 ++
 rtl/wave_gen_mc.sv | 107 ++++++++++
 3 files changed

// File: rtl/wave_gen_pkg.sv
// wave_gen_pkg: shared mode codes, register offsets and LFSR constants for wave_gen_mc
package wave_gen_pkg;
   typedef enum logic [2:0] {
      M_OFF    = 3'd0,
      M_SQUARE = 3'd1,
      M_SAW    = 3'd2,
      M_TRI    = 3'd3,
      M_SINE   = 3'd4,
      M_NOISE  = 3'd5
   } mode_e;
   localparam logic [1:0] W_CTRL = 2'd0;
   localparam logic [1:0] W_INC  = 2'd1;
   localparam logic [1:0] W_AMP  = 2'd2;
   localparam logic [1:0] W_DUTY = 2'd3;
   localparam logic [1:0] W_SYNC = 2'd0;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   function automatic logic [15:0] lfsr_next(input logic [15:0] r);
      return r[0] ? ((r >> 1) ^ LFSR_TAPS) : (r >> 1);
   endfunction
endpackage

// File: rtl/wave_sine_lut.sv
// wave_sine_lut: combinational quarter-wave sine ROM, entries evaluated at elaboration
module wave_sine_lut #(
   parameter int LUT_AW = 8,
   parameter int WAVE_W = 12
) (
   input  logic [LUT_AW-1:0] i_idx,
   output logic [WAVE_W-2:0] o_val
);
   function automatic logic [WAVE_W-2:0] entry(input int k);
      real x, t, s;
      x = 3.14159265358979 / 2.0 * (k + 0.5) / (2.0 ** LUT_AW);
      t = x;
      s = x;
      for (int n = 1; n < 8; n++) begin
         t = -t * x * x / ((2 * n) * (2 * n + 1));
         s = s + t;
      end
      return (WAVE_W-1)'($rtoi(((2.0 ** (WAVE_W - 1)) - 1.0) * s + 0.5));
   endfunction
   logic [WAVE_W-2:0] w_rom [2**LUT_AW];
   for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_rom
      localparam logic [WAVE_W-2:0] V = entry(k);
      assign w_rom[k] = V;
   end
   assign o_val = w_rom[i_idx];
endmodule

// File: rtl/wave_gen_mc.sv
// wave_gen_mc: multi-channel DDS waveform generator on the picosoc iomem bus
module wave_gen_mc
   import wave_gen_pkg::*;
#(
   parameter int NCH     = 4,
   parameter int PHASE_W = 24,
   parameter int WAVE_W  = 12,
   parameter int LUT_AW  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [3:0]              wstrb,
   input  logic [31:0]             addr,
   input  logic [31:0]             wdata,
   output logic [31:0]             rdata,
   output logic [NCH*WAVE_W-1:0]   wave
);
   localparam int CH_AW = (NCH > 1) ? $clog2(NCH) : 1;
   logic              w_wr, w_glob, w_sync, w_unused;
   logic [1:0]        w_word;
   logic [CH_AW-1:0]  w_ch;
   logic [3:0]        w_ctrl [NCH];
   logic [PHASE_W-1:0] w_inc [NCH];
   logic [WAVE_W-1:0] w_amp [NCH];
   logic [WAVE_W-1:0] w_duty [NCH];
   assign w_wr     = |wstrb;
   assign w_glob   = addr[4+CH_AW];
   assign w_word   = addr[3:2];
   assign w_ch     = addr[4 +: CH_AW];
   assign w_sync   = w_wr && w_glob && w_word == W_SYNC && wdata[0];
   assign w_unused = ^{addr[31:5+CH_AW], addr[1:0], wdata};
   // Readback of the addressed channel word; global block and absent channels read 0
   always_comb begin
      rdata = '0;
      if (!w_glob && 32'(w_ch) < NCH)
         rdata = (w_word == W_CTRL) ? 32'(w_ctrl[w_ch]) :
                 (w_word == W_INC)  ? 32'(w_inc[w_ch])  :
                 (w_word == W_AMP)  ? 32'(w_amp[w_ch])  : 32'(w_duty[w_ch]);
   end
   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [3:0]          r_ctrl;
      logic [PHASE_W-1:0]  r_inc, r_phase, w_sum;
      logic [WAVE_W-1:0]   r_amp, r_duty, r_s, r_out, w_p, w_t, w_s;
      logic [15:0]         r_lfsr;
      logic                w_sel, w_ctrl_wr, w_run, w_carry;
      logic [LUT_AW-1:0]   w_idx;
      logic [WAVE_W-2:0]   w_lut;
      logic [2*WAVE_W-1:0] w_prod;
      assign w_sel     = w_wr && !w_glob && w_ch == CH_AW'(g);
      assign w_ctrl_wr = w_sel && w_word == W_CTRL;
      assign w_run     = r_ctrl[3] && r_ctrl[2:0] != M_OFF && r_ctrl[2:0] <= M_NOISE;
      assign {w_carry, w_sum} = {1'b0, r_phase} + {1'b0, r_inc};
      assign w_p   = r_phase[PHASE_W-1 -: WAVE_W];
      assign w_t   = r_phase[PHASE_W-2 -: WAVE_W];
      assign w_idx = r_phase[PHASE_W-2] ? ~r_phase[PHASE_W-3 -: LUT_AW] : r_phase[PHASE_W-3 -: LUT_AW];
      assign w_prod = {{WAVE_W{1'b0}}, r_s} * {{WAVE_W{1'b0}}, r_amp} + {{WAVE_W{1'b0}}, r_s};
      wave_sine_lut #(.LUT_AW(LUT_AW), .WAVE_W(WAVE_W)) u_lut (.i_idx(w_idx), .o_val(w_lut));
      // Channel register writes
      always_ff @(posedge clk) begin
         if (reset) begin
            r_ctrl <= '0;
            r_inc  <= '0;
            r_amp  <= '0;
            r_duty <= '0;
         end else if (w_sel) begin
            if (w_word == W_CTRL) r_ctrl <= wdata[3:0];
            if (w_word == W_INC)  r_inc  <= wdata[PHASE_W-1:0];
            if (w_word == W_AMP)  r_amp  <= wdata[WAVE_W-1:0];
            if (w_word == W_DUTY) r_duty <= wdata[WAVE_W-1:0];
         end
      end
      // Phase accumulator and noise LFSR; zeroing beats accumulation
      always_ff @(posedge clk) begin
         if (reset) begin
            r_phase <= '0;
            r_lfsr  <= LFSR_SEED;
         end else begin
            r_phase <= (w_ctrl_wr || w_sync) ? '0 : w_run ? w_sum : r_phase;
            r_lfsr  <= w_ctrl_wr ? LFSR_SEED : (w_run && w_carry && !w_sync) ? lfsr_next(r_lfsr) : r_lfsr;
         end
      end
      // Shape selection from the current phase; sine halves fold around mid-scale
      always_comb begin
         w_s = !w_run                    ? '0 :
               (r_ctrl[2:0] == M_SQUARE) ? ((w_p < r_duty) ? '1 : '0) :
               (r_ctrl[2:0] == M_SAW)    ? w_p :
               (r_ctrl[2:0] == M_TRI)    ? (r_phase[PHASE_W-1] ? ~w_t : w_t) :
               (r_ctrl[2:0] == M_SINE)   ? (r_phase[PHASE_W-1] ? {1'b0, ~w_lut} : {1'b1, w_lut}) :
                                           r_lfsr[15 -: WAVE_W];
      end
      // Output pipeline: registered shape, then amplitude-scaled sample
      always_ff @(posedge clk) begin
         if (reset) begin
            r_s   <= '0;
            r_out <= '0;
         end else begin
            r_s   <= w_s;
            r_out <= WAVE_W'(w_prod >> WAVE_W);
         end
      end
      assign wave[g*WAVE_W +: WAVE_W] = r_out;
      assign w_ctrl[g] = r_ctrl;
      assign w_inc[g]  = r_inc;
      assign w_amp[g]  = r_amp;
      assign w_duty[g] = r_duty;
   end
endmodule
